// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the requesters and the 16-way round-robin arbiter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until granted, and done ends a grant.
interface rr_arbiter_16_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic        grant_valid;
    logic        timeout_flag;

    // Requester side: drives requests and completion, observes the grant.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_valid,
        input  timeout_flag
    );

    // Arbiter side: samples requests and completion, drives the grant.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_valid,
        output timeout_flag
    );
endinterface

// File: rtl/rr_arbiter_16.sv
// Sixteen-way round-robin arbiter producing a registered one-hot grant (optional hold timeout: ARB_TIMEOUT_EN).
// Latency: req sampled in IDLE -> grant visible after the same edge; done/withdraw -> grant drops after that edge.
// Backpressure: a grant is held until done or withdrawal (or timeout); other requests wait, no preemption.
module rr_arbiter_16 #(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    rr_arbiter_16_if.slave    bus
);

    // TIMEOUT is stored in the 8-bit hold counter, so it must fit 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter_16: TIMEOUT must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] grant_q, grant_nxt;
    logic        gv_q, gv_nxt;
    logic [3:0]  ptr, ptr_nxt;

    // Rotated view of the request vector so that bit 0 is the requester at ptr.
    logic [31:0] req_dbl;
    logic [15:0] req_rot;
    logic [3:0]  off;
    logic        hit;
    logic [3:0]  win;
    logic        release_now;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HCNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] hcnt, hcnt_nxt;
    logic       tflag_q, tflag_nxt;
`endif

    assign req_dbl = {bus.req, bus.req};
    assign win     = ptr + off;

    // The holder releases on completion or when its own request line drops.
    assign release_now = bus.done || ((bus.req & grant_q) == 16'h0000);

    // Find the first asserted request at or after ptr, wrapping modulo 16.
    always_comb begin
        req_rot = req_dbl[{1'b0, ptr} +: 16];
        hit     = |req_rot;
        off     = 4'd0;
        for (int j = 15; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = 4'(j);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        gv_nxt    = gv_q;
        ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
        hcnt_nxt  = hcnt;
        tflag_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (hit) begin
                    grant_nxt = 16'd1 << win;
                    gv_nxt    = 1'b1;
                    ptr_nxt   = win + 4'd1;
                    state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hcnt_nxt  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_nxt = 16'h0000;
                    gv_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hcnt == HCNT_LAST) begin
                    // Forced release; ptr already points past this holder.
                    grant_nxt = 16'h0000;
                    gv_nxt    = 1'b0;
                    tflag_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (hcnt != 8'hFF) begin
                    hcnt_nxt  = hcnt + 8'd1;
                end
`endif
            end
            default: begin
                grant_nxt = 16'h0000;
                gv_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset returns everything to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= 16'h0000;
            gv_q    <= 1'b0;
            ptr     <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            hcnt    <= 8'd0;
            tflag_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            gv_q    <= gv_nxt;
            ptr     <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            hcnt    <= hcnt_nxt;
            tflag_q <= tflag_nxt;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = gv_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout_flag = tflag_q;
`else
    assign bus.timeout_flag = 1'b0;
`endif

endmodule
